// File: rtl/alu_writeback.sv
// ALU result writeback stage: optional decimal adjust, register file commit
// (A/X/Y/S), stack pointer stepping and processor status flag maintenance.
module alu_writeback (
  input  logic       clk,
  input  logic       reset,
  input  logic       RDY,
  input  logic [7:0] alu_out,
  input  logic       alu_co,
  input  logic       alu_v,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       alu_hc,
  input  logic       adj_bcd,
  input  logic       adc_sbc,
  input  logic       wb_en,
  input  logic [1:0] wb_sel,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic [2:0] flag_op,
  input  logic       flag_val,
  input  logic       plp,
  input  logic [7:0] db_in,
  input  logic       irq_set_i,
  input  logic [1:0] sp_op,
  input  logic       brk_push,
  output logic [7:0] regA,
  output logic [7:0] regX,
  output logic [7:0] regY,
  output logic [7:0] regS,
  output logic [7:0] p_out,
  output logic       bcd
);

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_X = 2'b01;
  localparam logic [1:0] SEL_Y = 2'b10;
  localparam logic [1:0] SEL_S = 2'b11;

  // Per-nibble decimal correction; nibbles wrap independently, no inter-nibble carry.
  function automatic logic [7:0] bcd_adjust(input logic [7:0] v, input logic sub,
                                            input logic hc, input logic co);
    logic [3:0] lo_add;
    logic [3:0] hi_add;
    if (sub) begin
      lo_add = hc ? 4'h0 : 4'hA;
      hi_add = co ? 4'h0 : 4'hA;
    end else begin
      lo_add = hc ? 4'h6 : 4'h0;
      hi_add = co ? 4'h6 : 4'h0;
    end
    return {v[7:4] + hi_add, v[3:0] + lo_add};
  endfunction

  logic [7:0] a_q, x_q, y_q, s_q;
  logic [7:0] a_d, x_d, y_d, s_d;
  logic       n_q, v_q, d_q, i_q, z_q, c_q;
  logic       n_d, v_d, d_d, i_d, z_d, c_d;
  logic [7:0] res_s;

  // alu_n/alu_z are intentionally ignored: N/Z come from the adjusted result.
  logic unused_flags_s;
  assign unused_flags_s = alu_n ^ alu_z;

  // Result selection: raw ALU output or decimal-adjusted value.
  always_comb begin
    if (adj_bcd) begin
      res_s = bcd_adjust(alu_out, adc_sbc, alu_hc, alu_co);
    end else begin
      res_s = alu_out;
    end
  end

  // Register file next state; an explicit write to S beats stack stepping.
  always_comb begin
    a_d = (wb_en && (wb_sel == SEL_A)) ? res_s : a_q;
    x_d = (wb_en && (wb_sel == SEL_X)) ? res_s : x_q;
    y_d = (wb_en && (wb_sel == SEL_Y)) ? res_s : y_q;
    if (wb_en && (wb_sel == SEL_S)) begin
      s_d = res_s;
    end else begin
      case (sp_op)
        2'b01:   s_d = s_q + 8'd1;
        2'b10:   s_d = s_q - 8'd1;
        default: s_d = s_q;
      endcase
    end
  end

  // Flag next state, lowest to highest priority: upd_*, flag_op, plp, irq.
  always_comb begin
    n_d = upd_nz ? res_s[7] : n_q;
    z_d = upd_nz ? (res_s == 8'h00) : z_q;
    c_d = upd_c ? alu_co : c_q;
    v_d = upd_v ? alu_v : v_q;
    i_d = i_q;
    d_d = d_q;
    case (flag_op)
      3'b001:  c_d = flag_val;
      3'b010:  i_d = flag_val;
      3'b011:  d_d = flag_val;
      3'b100:  v_d = flag_val;
      default: d_d = d_q;
    endcase
    if (plp) begin
      n_d = db_in[7];
      v_d = db_in[6];
      d_d = db_in[3];
      i_d = db_in[2];
      z_d = db_in[1];
      c_d = db_in[0];
    end else begin
      d_d = d_d;
    end
    i_d = irq_set_i ? 1'b1 : i_d;
  end

  // State update: reset beats RDY, RDY low freezes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= 8'h00;
      x_q <= 8'h00;
      y_q <= 8'h00;
      s_q <= 8'hFF;
      n_q <= 1'b0;
      v_q <= 1'b0;
      d_q <= 1'b0;
      i_q <= 1'b1;
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else if (RDY) begin
      a_q <= a_d;
      x_q <= x_d;
      y_q <= y_d;
      s_q <= s_d;
      n_q <= n_d;
      v_q <= v_d;
      d_q <= d_d;
      i_q <= i_d;
      z_q <= z_d;
      c_q <= c_d;
    end else begin
      a_q <= a_q;
      x_q <= x_q;
      y_q <= y_q;
      s_q <= s_q;
      n_q <= n_q;
      v_q <= v_q;
      d_q <= d_q;
      i_q <= i_q;
      z_q <= z_q;
      c_q <= c_q;
    end
  end

  assign regA  = a_q;
  assign regX  = x_q;
  assign regY  = y_q;
  assign regS  = s_q;
  assign p_out = {n_q, v_q, 1'b1, brk_push, d_q, i_q, z_q, c_q};
  assign bcd   = d_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback with hand-computed expectations.
module tb_alu_writeback;

  logic       clk = 1'b0;
  logic       reset, RDY;
  logic [7:0] alu_out;
  logic       alu_co, alu_v, alu_z, alu_n, alu_hc;
  logic       adj_bcd, adc_sbc, wb_en;
  logic [1:0] wb_sel;
  logic       upd_nz, upd_c, upd_v;
  logic [2:0] flag_op;
  logic       flag_val, plp;
  logic [7:0] db_in;
  logic       irq_set_i;
  logic [1:0] sp_op;
  logic       brk_push;
  logic [7:0] regA, regX, regY, regS, p_out;
  logic       bcd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_writeback dut (
    .clk(clk), .reset(reset), .RDY(RDY), .alu_out(alu_out),
    .alu_co(alu_co), .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n), .alu_hc(alu_hc),
    .adj_bcd(adj_bcd), .adc_sbc(adc_sbc), .wb_en(wb_en), .wb_sel(wb_sel),
    .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v), .flag_op(flag_op),
    .flag_val(flag_val), .plp(plp), .db_in(db_in), .irq_set_i(irq_set_i),
    .sp_op(sp_op), .brk_push(brk_push), .regA(regA), .regX(regX), .regY(regY),
    .regS(regS), .p_out(p_out), .bcd(bcd)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; RDY = 1'b1; alu_out = 8'h00;
    alu_co = 1'b0; alu_v = 1'b0; alu_z = 1'b0; alu_n = 1'b0; alu_hc = 1'b0;
    adj_bcd = 1'b0; adc_sbc = 1'b0; wb_en = 1'b0; wb_sel = 2'b00;
    upd_nz = 1'b0; upd_c = 1'b0; upd_v = 1'b0; flag_op = 3'b000; flag_val = 1'b0;
    plp = 1'b0; db_in = 8'h00; irq_set_i = 1'b0; sp_op = 2'b00; brk_push = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_A", regA, 8'h00);
    chk("rst_X", regX, 8'h00);
    chk("rst_Y", regY, 8'h00);
    chk("rst_S", regS, 8'hFF);
    chk("rst_P", p_out, 8'h34);
    chk("rst_bcd", {7'd0, bcd}, 8'h00);

    // Decimal add adjust: 0x41 with half carry -> 0x47
    alu_out = 8'h41; alu_hc = 1'b1; alu_co = 1'b0; adj_bcd = 1'b1; adc_sbc = 1'b0;
    wb_en = 1'b1; wb_sel = 2'b00; upd_nz = 1'b1; upd_c = 1'b1;
    chk("lat_A_before", regA, 8'h00);
    tick(); idle();
    chk("bcd_add_A", regA, 8'h47);
    chk("bcd_add_P", p_out, 8'h34);

    // Decimal subtract adjust: 0x1F, no half carry, carry -> 0x19, C=1
    alu_out = 8'h1F; alu_hc = 1'b0; alu_co = 1'b1; adj_bcd = 1'b1; adc_sbc = 1'b1;
    wb_en = 1'b1; wb_sel = 2'b00; upd_c = 1'b1;
    tick(); idle();
    chk("bcd_sub_A", regA, 8'h19);
    chk("bcd_sub_P", p_out, 8'h35);

    // Zero result into X sets Z; negative into Y sets N; A holds
    alu_out = 8'h00; wb_en = 1'b1; wb_sel = 2'b01; upd_nz = 1'b1;
    tick(); idle();
    chk("wbX", regX, 8'h00);
    chk("Z_set_P", p_out, 8'h37);
    alu_out = 8'h85; wb_en = 1'b1; wb_sel = 2'b10; upd_nz = 1'b1;
    tick(); idle();
    chk("wbY", regY, 8'h85);
    chk("N_set_P", p_out, 8'hB5);
    chk("A_hold", regA, 8'h19);

    // Stack pointer wrap both ways and write-over-step priority
    sp_op = 2'b01;
    tick(); idle();
    chk("S_inc_wrap", regS, 8'h00);
    sp_op = 2'b10;
    tick(); idle();
    chk("S_dec_wrap", regS, 8'hFF);
    sp_op = 2'b01;
    tick(); idle();
    chk("S_inc", regS, 8'h00);
    sp_op = 2'b01; wb_en = 1'b1; wb_sel = 2'b11; alu_out = 8'h80;
    tick(); idle();
    chk("S_wb_wins", regS, 8'h80);
    chk("S_wb_A_hold", regA, 8'h19);

    // D flag write, visible on bcd only after the edge
    flag_op = 3'b011; flag_val = 1'b1;
    #1;
    chk("bcd_not_yet", {7'd0, bcd}, 8'h00);
    tick(); idle();
    chk("bcd_set", {7'd0, bcd}, 8'h01);
    chk("D_set_P", p_out, 8'hBD);

    // flag_op beats upd_c / upd_v; reserved code changes nothing
    upd_c = 1'b1; alu_co = 1'b1; flag_op = 3'b001; flag_val = 1'b0;
    tick(); idle();
    chk("flagop_C_wins", p_out, 8'hBC);
    upd_v = 1'b1; alu_v = 1'b0; flag_op = 3'b100; flag_val = 1'b1;
    tick(); idle();
    chk("flagop_V_wins", p_out, 8'hFC);
    flag_op = 3'b101; flag_val = 1'b0;
    tick(); idle();
    chk("flagop_reserved", p_out, 8'hFC);

    // plp load, then irq overriding both plp and flag_op on I
    plp = 1'b1; db_in = 8'hCF; upd_nz = 1'b1; alu_out = 8'h00;
    tick(); idle();
    chk("plp_P", p_out, 8'hFF);
    plp = 1'b1; db_in = 8'h00; irq_set_i = 1'b1; flag_op = 3'b010; flag_val = 1'b0;
    tick(); idle();
    chk("irq_wins_P", p_out, 8'h34);

    // Reset during RDY=0 with pending updates
    plp = 1'b1; db_in = 8'hFF; tick(); idle();
    reset = 1'b1; RDY = 1'b0; wb_en = 1'b1; wb_sel = 2'b11; alu_out = 8'h55; sp_op = 2'b01;
    tick(); idle();
    chk("rst_mid_P", p_out, 8'h34);
    chk("rst_mid_S", regS, 8'hFF);
    chk("rst_mid_A", regA, 8'h00);

    // RDY=0 freezes everything
    RDY = 1'b0; wb_en = 1'b1; wb_sel = 2'b00; alu_out = 8'h99; upd_c = 1'b1; alu_co = 1'b1;
    flag_op = 3'b001; flag_val = 1'b1; sp_op = 2'b01; upd_nz = 1'b1;
    tick(); idle();
    chk("rdy0_A", regA, 8'h00);
    chk("rdy0_S", regS, 8'hFF);
    chk("rdy0_P", p_out, 8'h34);
    upd_c = 1'b1; alu_co = 1'b0; flag_op = 3'b001; flag_val = 1'b1;
    tick(); idle();
    chk("rdy1_C", p_out, 8'h35);

    // brk_push=0 clears bit 4 combinationally
    flag_op = 3'b001; flag_val = 1'b0;
    tick(); idle();
    chk("C_clr_P", p_out, 8'h34);
    brk_push = 1'b0;
    #1;
    chk("brk0_P", p_out, 8'h24);
    brk_push = 1'b1;
    #1;
    chk("brk1_P", p_out, 8'h34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 RDY  in  1  global advance enable; 0 = all state holds.
REQ-004 alu_out  in  8  registered ALU result.
REQ-005 alu_co, alu_v, alu_z, alu_n, alu_hc  in  1 each  registered ALU carry, overflow, zero, negative and half-carry flags.
REQ-006 adj_bcd  in  1  apply decimal adjust to alu_out this cycle.
REQ-007 adc_sbc  in  1  adjust direction: 0 = add, 1 = subtract.
REQ-008 wb_en  in  1  commit result to the register selected by wb_sel.
REQ-009 wb_sel  in  2  destination select: 00 = A, 01 = X, 10 = Y, 11 = S.
REQ-010 upd_nz, upd_c, upd_v  in  1 each  load N/Z, C and V from this cycle's result.
REQ-011 flag_op  in  3  explicit flag write: 000 = none, 001 = C, 010 = I, 011 = D, 100 = V; all other codes = none.
REQ-012 flag_val  in  1  value written by flag_op.
REQ-013 plp  in  1  load P from db_in.
REQ-014 db_in  in  8  data bus input.
REQ-015 irq_set_i  in  1  interrupt entry; sets I.
REQ-016 sp_op  in  2  stack pointer op: 00 = hold, 01 = +1, 10 = -1, 11 = hold.
REQ-017 brk_push  in  1  0 forces p_out[4] to 0 (hardware interrupt push).
REQ-018 regA, regX, regY, regS  out  8 each  architectural registers.
REQ-019 p_out  out  8  status {N,V,1,B,D,I,Z,C}.
REQ-020 bcd  out  1  current D flag; drives the ALU BCD input.

Function
REQ-021 The block SHALL compute res = alu_out when adj_bcd = 0; otherwise res SHALL be alu_out with each nibble adjusted modulo 16 and no carry between nibbles.
REQ-022 Add adjust (adc_sbc = 0) SHALL add 6 to the low nibble when alu_hc = 1 and add 6 to the high nibble when alu_co = 1.
REQ-023 Subtract adjust (adc_sbc = 1) SHALL add 0xA to the low nibble when alu_hc = 0 and add 0xA to the high nibble when alu_co = 0.
REQ-024 The block SHALL have one-cycle latency: res is written on the first rising edge where RDY = 1 and wb_en = 1.
REQ-025 When RDY = 0, the block SHALL hold all registers and P regardless of any other input.
REQ-026 upd_nz SHALL load N = res[7] and Z = (res == 0); N and Z are computed from the adjusted value, not from alu_n/alu_z.
REQ-027 upd_c SHALL load C = alu_co.
REQ-028 upd_v SHALL load V = alu_v.
REQ-029 plp SHALL load N, V, D, I, Z, C from db_in bits 7, 6, 3, 2, 1, 0; when plp = 1, it SHALL override upd_* and flag_op on those bits.
REQ-030 When flag_op targets a bit also targeted by upd_* in the same cycle, flag_op SHALL win.
REQ-031 irq_set_i SHALL force I = 1 and SHALL override both plp and flag_op on I.
REQ-032 p_out[5] SHALL always be 1.
REQ-033 p_out[4] SHALL be 1, except 0 while brk_push = 0 (combinational).
REQ-034 sp_op SHALL update S modulo 256: 0xFF + 1 = 0x00 and 0x00 - 1 = 0xFF.
REQ-035 When wb_en = 1 and wb_sel = 11 in the same cycle as a nonzero sp_op, the wb_en write SHALL win and sp_op SHALL be ignored.
REQ-036 Registers not selected by wb_sel, and flags not updated, SHALL hold.
REQ-037 bcd SHALL equal the stored D flag; a change of D SHALL become visible the cycle after the write.

Reset
REQ-038 While reset = 1 at a rising edge, the block SHALL load regA = regX = regY = 0x00, regS = 0xFF and N = V = D = Z = C = 0, I = 1, giving p_out = 0x34 with brk_push = 1.
REQ-039 Reset SHALL take priority over RDY = 0 and over every update input, including when asserted mid-operation.

Verification
REQ-040 alu_out = 0x41, alu_hc = 1, alu_co = 0, adj_bcd = 1, adc_sbc = 0, wb_en = 1, wb_sel = 00, upd_nz = 1, upd_c = 1 -> next cycle regA = 0x47, C = 0, Z = 0, N = 0.
REQ-041 alu_out = 0x1F, alu_hc = 0, alu_co = 1, adj_bcd = 1, adc_sbc = 1, wb_en = 1, wb_sel = 00 -> regA = 0x19, C = 1.
REQ-042 regS = 0x00, sp_op = 10 -> regS = 0xFF; then sp_op = 01 -> regS = 0x00; then sp_op = 01 with wb_en = 1, wb_sel = 11, alu_out = 0x80 -> regS = 0x80.
REQ-043 plp = 1, db_in = 0xCF -> p_out = 0xFF; then irq_set_i = 1 with flag_op = 010, flag_val = 0 -> I = 1; then reset = 1 -> p_out = 0x34, regS = 0xFF.
REQ-044 RDY = 0 with wb_en = 1, upd_c = 1, flag_op = 001, sp_op = 01 -> regA, regS and p_out unchanged; set upd_c = 1, alu_co = 0, flag_op = 001, flag_val = 1, RDY = 1 -> C = 1.
REQ-045 brk_push = 0 with p_out otherwise 0x34 -> p_out = 0x24, combinationally in the same cycle.
